// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: ALU control codes,
// command/condition/state encodings, flag bit positions and code helpers.
package alu_seq_pkg;

  // ALU control codes understood by the clocked ALU
  localparam logic [5:0] ALU_ADD      = 6'd0;
  localparam logic [5:0] ALU_SUB      = 6'd1;
  localparam logic [5:0] ALU_PASS1    = 6'd2;
  localparam logic [5:0] ALU_PASS2    = 6'd3;
  localparam logic [5:0] ALU_NOT1     = 6'd4;
  localparam logic [5:0] ALU_NOT2     = 6'd5;
  localparam logic [5:0] ALU_NEG1     = 6'd6;
  localparam logic [5:0] ALU_NEG2     = 6'd7;
  localparam logic [5:0] ALU_AND      = 6'd8;
  localparam logic [5:0] ALU_OR       = 6'd9;
  localparam logic [5:0] ALU_XOR      = 6'd10;
  localparam logic [5:0] ALU_NAND     = 6'd11;
  localparam logic [5:0] ALU_NOR      = 6'd12;
  localparam logic [5:0] ALU_XNOR     = 6'd13;
  localparam logic [5:0] ALU_ADC      = 6'd14;
  localparam logic [5:0] ALU_SBC      = 6'd15;
  localparam logic [5:0] ALU_SHL1     = 6'd16;
  localparam logic [5:0] ALU_SHL2     = 6'd17;
  localparam logic [5:0] ALU_SHR1     = 6'd18;
  localparam logic [5:0] ALU_SHR2     = 6'd19;
  localparam logic [5:0] ALU_ROL1     = 6'd20;
  localparam logic [5:0] ALU_ROL2     = 6'd21;
  localparam logic [5:0] ALU_ROR1     = 6'd22;
  localparam logic [5:0] ALU_ROR2     = 6'd23;
  localparam logic [5:0] ALU_MAX_CODE = 6'd23;

  // Flag bit positions inside {V,Z,C,N}
  localparam int FLAG_V = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    OP_SINGLE = 2'd0,
    OP_REPEAT = 2'd1,
    OP_CMP    = 2'd2,
    OP_RSVD   = 2'd3
  } cmd_op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Unary operations on in_1 are the only ones that may be iterated
  function automatic logic is_unary_in1(input logic [5:0] code);
    case (code)
      ALU_NOT1, ALU_NEG1, ALU_SHL1, ALU_SHR1, ALU_ROL1, ALU_ROR1: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle between the decode/control unit
// (master) and the ALU command sequencer (slave).
interface alu_cmd_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [5:0]        cmd_code;
  logic [CNT_W-1:0]  cmd_cnt;
  logic [3:0]        cmd_cond;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [3:0]        rsp_flags;
  logic              rsp_cond_true;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_code, cmd_cnt, cmd_cond, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_cond_true, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_code, cmd_cnt, cmd_cond, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_cond_true, rsp_err
  );
endinterface

// File: rtl/alu_cmd_sequencer_cond_eval.sv
// ARM-style condition code evaluation on a {V,Z,C,N} flag vector.
module alu_cond_eval
  import alu_seq_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       cond_true
);

  logic v_s, z_s, c_s, n_s;

  assign v_s = flags[FLAG_V];
  assign z_s = flags[FLAG_Z];
  assign c_s = flags[FLAG_C];
  assign n_s = flags[FLAG_N];

  // Decode the condition against the flags
  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond))
      COND_EQ: cond_true = z_s;
      COND_NE: cond_true = ~z_s;
      COND_CS: cond_true = c_s;
      COND_CC: cond_true = ~c_s;
      COND_MI: cond_true = n_s;
      COND_PL: cond_true = ~n_s;
      COND_VS: cond_true = v_s;
      COND_VC: cond_true = ~v_s;
      COND_HI: cond_true = c_s & ~z_s;
      COND_LS: cond_true = ~c_s | z_s;
      COND_GE: cond_true = (n_s == v_s);
      COND_LT: cond_true = (n_s != v_s);
      COND_GT: cond_true = ~z_s & (n_s == v_s);
      COND_LE: cond_true = z_s | (n_s != v_s);
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the clocked ALU: accepts commands, issues single or iterated
// ALU operations, tracks the flag register and returns result, flags and the
// evaluated condition through a response handshake. All outputs are registered.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int         DATA_W    = 32,
  parameter int         CNT_W     = 5,
  parameter logic [5:0] IDLE_CODE = 6'd2
) (
  input  logic              seq_clk,
  input  logic              seq_rst_n,
  alu_cmd_sequencer_if.slave bus,
  output logic [5:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_in_1,
  output logic [DATA_W-1:0] alu_in_2,
  input  logic [DATA_W-1:0] alu_rslt,
  input  logic [3:0]        alu_checks
);

  state_e            state_q, state_d;
  cmd_op_e           op_q, op_d, cmd_op_s;
  logic [5:0]        code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        cond_q, cond_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] work_a_q, work_a_d;
  logic [3:0]        flags_q, flags_d;
  logic              err_q, err_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_cond_true_q, rsp_cond_true_d;
  logic [5:0]        alu_ctrl_q, alu_ctrl_d;
  logic [DATA_W-1:0] alu_in_1_q, alu_in_1_d;
  logic [DATA_W-1:0] alu_in_2_q, alu_in_2_d;
  logic              illegal_s;
  logic              cond_true_s;

  alu_cond_eval u_cond_eval (
    .flags     (flags_q),
    .cond      (cond_q),
    .cond_true (cond_true_s)
  );

  // Classify the incoming command as legal or illegal
  always_comb begin
    cmd_op_s  = cmd_op_e'(bus.cmd_op);
    illegal_s = 1'b0;
    case (cmd_op_s)
      OP_SINGLE: illegal_s = (bus.cmd_code > ALU_MAX_CODE);
      OP_REPEAT: illegal_s = (bus.cmd_code > ALU_MAX_CODE) || !is_unary_in1(bus.cmd_code);
      OP_CMP:    illegal_s = 1'b0;
      default:   illegal_s = 1'b1;
    endcase
  end

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    code_d          = code_q;
    cnt_d           = cnt_q;
    cond_d          = cond_q;
    a_d             = a_q;
    b_d             = b_q;
    work_a_d        = work_a_q;
    flags_d         = flags_q;
    err_d           = err_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_data_d      = rsp_data_q;
    rsp_cond_true_d = rsp_cond_true_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          op_d     = cmd_op_s;
          code_d   = bus.cmd_code;
          cond_d   = bus.cmd_cond;
          a_d      = bus.cmd_a;
          b_d      = bus.cmd_b;
          work_a_d = bus.cmd_a;
          if (cmd_op_s == OP_REPEAT) begin
            cnt_d = bus.cmd_cnt;
          end else begin
            cnt_d = CNT_W'(1'b1);
          end
          if (illegal_s) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if ((cmd_op_s == OP_REPEAT) && (bus.cmd_cnt == {CNT_W{1'b0}})) begin
            // Zero iterations: answer with the untouched operand
            err_d   = 1'b0;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // ALU result from the ISSUE cycle is visible now
        work_a_d = alu_rslt;
        flags_d  = alu_checks;
        cnt_d    = cnt_q - CNT_W'(1'b1);
        if ((op_q == OP_REPEAT) && (cnt_q > CNT_W'(1'b1))) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (!rsp_valid_q) begin
          // First RESP cycle registers the response from the final flags
          rsp_valid_d = 1'b1;
          if (err_q) begin
            rsp_data_d      = {DATA_W{1'b0}};
            rsp_cond_true_d = 1'b0;
          end else if (op_q == OP_CMP) begin
            rsp_data_d      = a_q;
            rsp_cond_true_d = cond_true_s;
          end else begin
            rsp_data_d      = work_a_q;
            rsp_cond_true_d = cond_true_s;
          end
        end else if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);

    if ((state_d == ST_ISSUE) || (state_d == ST_WAIT)) begin
      alu_ctrl_d = (op_d == OP_CMP) ? ALU_SUB : code_d;
      alu_in_1_d = work_a_d;
      alu_in_2_d = b_d;
    end else begin
      alu_ctrl_d = IDLE_CODE;
      alu_in_1_d = {DATA_W{1'b0}};
      alu_in_2_d = {DATA_W{1'b0}};
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge seq_clk or negedge seq_rst_n) begin
    if (!seq_rst_n) begin
      state_q         <= ST_IDLE;
      op_q            <= OP_SINGLE;
      code_q          <= 6'd0;
      cnt_q           <= {CNT_W{1'b0}};
      cond_q          <= 4'd0;
      a_q             <= {DATA_W{1'b0}};
      b_q             <= {DATA_W{1'b0}};
      work_a_q        <= {DATA_W{1'b0}};
      flags_q         <= 4'd0;
      err_q           <= 1'b0;
      cmd_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= {DATA_W{1'b0}};
      rsp_cond_true_q <= 1'b0;
      alu_ctrl_q      <= IDLE_CODE;
      alu_in_1_q      <= {DATA_W{1'b0}};
      alu_in_2_q      <= {DATA_W{1'b0}};
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      code_q          <= code_d;
      cnt_q           <= cnt_d;
      cond_q          <= cond_d;
      a_q             <= a_d;
      b_q             <= b_d;
      work_a_q        <= work_a_d;
      flags_q         <= flags_d;
      err_q           <= err_d;
      cmd_ready_q     <= cmd_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_cond_true_q <= rsp_cond_true_d;
      alu_ctrl_q      <= alu_ctrl_d;
      alu_in_1_q      <= alu_in_1_d;
      alu_in_2_q      <= alu_in_2_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_flags     = flags_q;
  assign bus.rsp_cond_true = rsp_cond_true_q;
  assign bus.rsp_err       = err_q;
  assign alu_ctrl          = alu_ctrl_q;
  assign alu_in_1          = alu_in_1_q;
  assign alu_in_2          = alu_in_2_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a small clocked ALU model.
module tb_alu_cmd_sequencer;

  localparam int         DW   = 32;
  localparam int         CW   = 5;
  localparam logic [5:0] IDLE = 6'd2;

  logic          seq_clk = 1'b0;
  logic          seq_rst_n;
  logic [5:0]    alu_ctrl;
  logic [DW-1:0] alu_in_1, alu_in_2;
  logic [DW-1:0] alu_rslt = '0;
  logic [3:0]    alu_checks = 4'd0;

  alu_cmd_sequencer_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  alu_cmd_sequencer #(.DATA_W(DW), .CNT_W(CW), .IDLE_CODE(IDLE)) dut (
    .seq_clk    (seq_clk),
    .seq_rst_n  (seq_rst_n),
    .bus        (bus),
    .alu_ctrl   (alu_ctrl),
    .alu_in_1   (alu_in_1),
    .alu_in_2   (alu_in_2),
    .alu_rslt   (alu_rslt),
    .alu_checks (alu_checks)
  );

  always #5 seq_clk = ~seq_clk;

  // Clocked ALU model: only the codes used by this bench are modelled
  logic [DW-1:0] m_r;
  logic          m_c, m_v;
  always @(posedge seq_clk) begin
    m_c = 1'b0;
    m_v = 1'b0;
    case (alu_ctrl)
      6'd0: begin
        {m_c, m_r} = {1'b0, alu_in_1} + {1'b0, alu_in_2};
        m_v = (alu_in_1[DW-1] == alu_in_2[DW-1]) && (m_r[DW-1] != alu_in_1[DW-1]);
      end
      6'd1: begin
        {m_c, m_r} = {1'b0, alu_in_1} - {1'b0, alu_in_2};
        m_c = ~m_c;
        m_v = (alu_in_1[DW-1] != alu_in_2[DW-1]) && (m_r[DW-1] != alu_in_1[DW-1]);
      end
      6'd4:  m_r = ~alu_in_1;
      6'd16: begin m_r = alu_in_1 << 1; m_c = alu_in_1[DW-1]; end
      6'd20: begin m_r = {alu_in_1[DW-2:0], alu_in_1[DW-1]}; m_c = alu_in_1[DW-1]; end
      default: m_r = alu_in_1;
    endcase
    alu_rslt   <= m_r;
    alu_checks <= {m_v, (m_r == '0), m_c, m_r[DW-1]};
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic [3:0]    flags;
    logic          ct;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted response against the scoreboard head
  always @(negedge seq_clk) begin
    if (seq_rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", sb_q.size(), 1);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_data",  bus.rsp_data,  mon_e.data);
        check("rsp_flags", {28'd0, bus.rsp_flags}, {28'd0, mon_e.flags});
        check("rsp_cond",  {31'd0, bus.rsp_cond_true}, {31'd0, mon_e.ct});
        check("rsp_err",   {31'd0, bus.rsp_err}, {31'd0, mon_e.err});
      end
    end
  end

  // Issue one command, push its expectation, check latency, ALU drive and handshake
  task automatic run_cmd(
    input logic [1:0] op, input logic [5:0] code, input logic [CW-1:0] cnt,
    input logic [3:0] cond, input logic [DW-1:0] a, input logic [DW-1:0] b,
    input logic [DW-1:0] e_data, input logic [3:0] e_flags, input logic e_ct,
    input logic e_err, input int e_lat, input int e_busy, input logic [5:0] e_ctrl,
    input int hold);
    int   n, lat, busy;
    logic ctrl_ok, stable;
    logic [DW-1:0] s_data;
    logic [3:0]    s_flags;
    logic          s_ct, s_err;
    exp_t e;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(posedge seq_clk); #1;
      n++;
    end
    check("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
    bus.rsp_ready = (hold == 0);
    bus.cmd_op    = op;
    bus.cmd_code  = code;
    bus.cmd_cnt   = cnt;
    bus.cmd_cond  = cond;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    e.data = e_data; e.flags = e_flags; e.ct = e_ct; e.err = e_err;
    sb_q.push_back(e);
    @(posedge seq_clk); #1;
    bus.cmd_valid = 1'b0;
    lat = 0; busy = 0; ctrl_ok = 1'b1;
    while (!bus.rsp_valid && lat < 100) begin
      if (alu_ctrl != IDLE) begin
        busy++;
        if (alu_ctrl != e_ctrl) ctrl_ok = 1'b0;
      end
      @(posedge seq_clk); #1;
      lat++;
    end
    check("latency", lat, e_lat);
    check("alu_busy_cycles", busy, e_busy);
    check("alu_ctrl_code", {31'd0, ctrl_ok}, 32'd1);
    check("resp_alu_idle", {26'd0, alu_ctrl}, {26'd0, IDLE});
    if (hold > 0) begin
      s_data = bus.rsp_data; s_flags = bus.rsp_flags;
      s_ct = bus.rsp_cond_true; s_err = bus.rsp_err;
      bus.cmd_op = 2'd0; bus.cmd_code = 6'd0; bus.cmd_a = 32'h1111; bus.cmd_b = 32'h2222;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge seq_clk); #1;
        stable = bus.rsp_valid && !bus.cmd_ready && (bus.rsp_data == s_data) &&
                 (bus.rsp_flags == s_flags) && (bus.rsp_cond_true == s_ct) &&
                 (bus.rsp_err == s_err) && (alu_ctrl == IDLE);
        check("bp_stable", {31'd0, stable}, 32'd1);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
    end
    @(posedge seq_clk); #1;
    check("idle_after_rsp", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_code = 6'd0; bus.cmd_cnt = '0;
    bus.cmd_cond = 4'd0; bus.cmd_a = '0; bus.cmd_b = '0; bus.rsp_ready = 1'b1;
    seq_rst_n = 1'b1;
    #1 seq_rst_n = 1'b0;
    #2;
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_alu_ctrl",  {26'd0, alu_ctrl}, {26'd0, IDLE});
    check("rst_alu_in",    alu_in_1 | alu_in_2, 32'd0);
    check("rst_rsp",       {bus.rsp_data[27:0], bus.rsp_flags} | {30'd0, bus.rsp_err, bus.rsp_cond_true}, 32'd0);
    repeat (2) @(posedge seq_clk);
    #1 check("rst_cmd_ready_clk", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge seq_clk) seq_rst_n = 1'b1;
    @(posedge seq_clk); #1;
    check("post_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);

    //      op    code   cnt    cond   a             b      e_data        flags    ct    err   lat busy ctrl   hold
    run_cmd(2'd0, 6'd0,  5'd0, 4'd11, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b1001, 1'b0, 1'b0, 3, 2, 6'd0,  0);
    run_cmd(2'd2, 6'd0,  5'd0, 4'd0,  32'd5,        32'd5, 32'd5,        4'b0110, 1'b1, 1'b0, 3, 2, 6'd1,  0);
    run_cmd(2'd2, 6'd9,  5'd0, 4'd11, 32'd3,        32'd5, 32'd3,        4'b0001, 1'b1, 1'b0, 3, 2, 6'd1,  0);
    run_cmd(2'd1, 6'd16, 5'd4, 4'd0,  32'h1,        32'd0, 32'h10,       4'b0000, 1'b0, 1'b0, 9, 8, 6'd16, 0);
    run_cmd(2'd1, 6'd20, 5'd1, 4'd2,  32'h80000001, 32'd0, 32'h3,        4'b0010, 1'b1, 1'b0, 3, 2, 6'd20, 0);
    run_cmd(2'd0, 6'd30, 5'd0, 4'd14, 32'h1234,     32'd5, 32'd0,        4'b0010, 1'b0, 1'b1, 1, 0, IDLE,  0);
    run_cmd(2'd1, 6'd0,  5'd3, 4'd14, 32'h55,       32'd0, 32'd0,        4'b0010, 1'b0, 1'b1, 1, 0, IDLE,  0);
    run_cmd(2'd1, 6'd16, 5'd0, 4'd2,  32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 4'b0010, 1'b1, 1'b0, 1, 0, IDLE,  0);
    run_cmd(2'd3, 6'd0,  5'd0, 4'd14, 32'd1,        32'd1, 32'd0,        4'b0010, 1'b0, 1'b1, 1, 0, IDLE,  0);
    run_cmd(2'd0, 6'd0,  5'd0, 4'd9,  32'hFFFFFFFF, 32'd1, 32'd0,        4'b0110, 1'b1, 1'b0, 3, 2, 6'd0,  5);

    // Reset in the middle of an iterated NOT, no response may follow
    bus.cmd_op = 2'd1; bus.cmd_code = 6'd4; bus.cmd_cnt = 5'd8; bus.cmd_cond = 4'd14;
    bus.cmd_a = 32'd0; bus.cmd_b = 32'd0; bus.cmd_valid = 1'b1;
    @(posedge seq_clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (3) begin
      @(posedge seq_clk); #1;
    end
    check("pre_rst_flags", {28'd0, bus.rsp_flags}, 32'h1);
    check("pre_rst_ctrl",  {26'd0, alu_ctrl}, 32'd4);
    seq_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("mid_rst_flags", {28'd0, bus.rsp_flags}, 32'd0);
    check("mid_rst_ctrl",  {26'd0, alu_ctrl}, {26'd0, IDLE});
    @(negedge seq_clk) seq_rst_n = 1'b1;
    @(posedge seq_clk); #1;
    check("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    run_cmd(2'd0, 6'd0, 5'd0, 4'd1, 32'd2, 32'd3, 32'd5, 4'b0000, 1'b1, 1'b0, 3, 2, 6'd0, 0);

    repeat (4) @(posedge seq_clk);
    #1 check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
